pipe_stage: RTL and testbench
=============================

Name: pipe_stage

Overview:
- Generic, parametrised pipeline-stage register for the RV32 core. It replaces the fixed per-stage register blocks.
- Carries a destination register, write-enable, data word, immediate-select and opcode, plus a valid bit.
- Adds stall (hold), flush (bubble insert) and x0 write suppression.
- Provides registered-state hazard-match outputs so the stalling and forwarding logic can compare a stage against the source registers of the decode stage.

Parameters:
- DATA_W, 32, width of data word
- RD_W, 5, register-index width
- OPC_W, 5, opcode field width
- IMM_SEL_W, 3, immediate-select field width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold all stage registers this cycle
- flush_i  in  1  replace stage contents with a bubble
- valid_i  in  1  upstream instruction valid
- rd_i  in  RD_W  destination register
- rd_wren_i  in  1  destination write-enable
- data_i  in  DATA_W  data word (ALU/mem mux result)
- imm_select_i  in  IMM_SEL_W  immediate-select code
- opcode_i  in  OPC_W  opcode field
- rs1_i  in  RD_W  decode-stage source 1, for hazard compare
- rs2_i  in  RD_W  decode-stage source 2, for hazard compare
- valid_o  out  1  stage holds a live instruction
- rd_o  out  RD_W  registered rd
- rd_wren_o  out  1  registered, qualified write-enable
- data_o  out  DATA_W  registered data
- imm_select_o  out  IMM_SEL_W  registered immediate-select
- opcode_o  out  OPC_W  registered opcode
- hit_rs1_o  out  1  stage will write rs1_i
- hit_rs2_o  out  1  stage will write rs2_i

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high: rst, sampled on the rising edge of clk.
- Update priority at each rising edge: rst > flush_i > stall_i > load.
- rst: valid_o=0, rd_o=0, rd_wren_o=0, data_o=0, imm_select_o=0, opcode_o=0 (NOP_OPC). Reset mid-stall or mid-flush also clears everything.
- flush_i=1 (regardless of stall_i):
  - valid_o=0, rd_wren_o=0, rd_o=0, opcode_o=NOP_OPC, imm_select_o=0, data_o=0.
  - The next cycle shows a pure bubble.
- stall_i=1, flush_i=0: every register keeps its value. Inputs are ignored.
- Load (rst=0, flush_i=0, stall_i=0): all fields captured; latency exactly 1 cycle.
  - valid_o <= valid_i.
  - rd_wren_o <= rd_wren_i & valid_i & (rd_i != 0). This suppresses x0 writes and invalid writes.
  - rd_o, data_o, imm_select_o and opcode_o are captured unchanged even when valid_i=0.
- Hazard outputs are combinational from registered state plus rs inputs. No register is added:
  - hit_rs1_o = valid_o & rd_wren_o & (rs1_i != 0) & (rd_o == rs1_i). hit_rs2_o is the same with rs2_i.
  - They remain valid during a stall, since they reflect the held contents.
  - They are 0 the cycle after a flush or reset.
- No X propagation: every output is driven by a register or by logic on registered state.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - Extra ports stall_cnt_o (out, 32) and bubble_cnt_o (out, 32).
  - stall_cnt_o increments on each edge with stall_i=1 & flush_i=0 & rst=0.
  - bubble_cnt_o increments on each edge where the stage loads or flushes to valid_o=0: flush_i=1, or a load with valid_i=0.
  - Both saturate at 32'hFFFFFFFF and clear only on rst.
- Undefined: no counter ports and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - constants DATA_W_DEF=32, RD_W_DEF=5, OPC_W_DEF=5, IMM_SEL_W_DEF=3;
  - NOP_OPC (all zeros);
  - typedef imm_sel_t for immediate-select codes.
- Optional sub-module pipe_sat_cnt: 32-bit saturating counter with clk, rst, inc_i, cnt_o. It is instantiated twice under the macro.
- Core stage logic stays in pipe_stage.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs nonzero -> every output 0, hit_rs1_o=hit_rs2_o=0. With the macro, both counters read 0.
- Load and x0 suppression:
  - valid_i=1, rd_i=5, rd_wren_i=1, data_i=32'hDEADBEEF -> next cycle rd_o=5, rd_wren_o=1, data_o=32'hDEADBEEF.
  - Same with rd_i=0 -> rd_wren_o=0.
- Stall hold: load rd_i=7/data 32'h12345678, then stall_i=1 for 3 cycles with new inputs -> outputs unchanged for all 3 cycles. With rs1_i=7, hit_rs1_o=1 throughout.
- Flush priority: stall_i=1 and flush_i=1 in the same cycle with rd_o=9 live -> next cycle valid_o=0, rd_wren_o=0, opcode_o=0, hit outputs 0.
- Hazard compare: stage holds rd_o=3, rd_wren_o=1, valid_o=1.
  - rs1_i=3, rs2_i=4 -> hit_rs1_o=1, hit_rs2_o=0.
  - rs1_i=0 -> hit_rs1_o=0.
- Counters (macro on):
  - 4 stall cycles and 2 flushes -> stall_cnt_o=4, bubble_cnt_o=2.
  - Force stall_cnt to 32'hFFFFFFFE, then stall 3 cycles -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 pipeline-stage registers: default field
// widths, the bubble opcode and the immediate-select code type.
package pipe_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned RD_W_DEF      = 5;
   localparam int unsigned OPC_W_DEF     = 5;
   localparam int unsigned IMM_SEL_W_DEF = 3;

   // Opcode presented by a bubble (reset or flush).
   localparam logic [OPC_W_DEF-1:0] NOP_OPC = '0;

   typedef logic [IMM_SEL_W_DEF-1:0] imm_sel_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter, cleared only by reset.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, clears the count
//   inc_i  count one event on this edge
//   cnt_o  current count, sticks at all-ones
module pipe_sat_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [31:0] cnt_o
);

   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] cnt;

   // Increment unless already at the ceiling.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc_i && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign cnt_o = cnt;

endmodule

// File: rtl/pipe_stage.sv
// Generic RV32 pipeline-stage register with stall (hold), flush (bubble),
// x0 write suppression and hazard-match outputs for decode-stage sources.
// Update priority per edge: rst > flush_i > stall_i > load.
// Optional macro PIPE_STAGE_PERF_CNT_EN adds saturating stall/bubble counters.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   stall_i, flush_i    hold stage / replace stage with bubble
//   valid_i .. opcode_i upstream instruction fields
//   rs1_i, rs2_i        decode-stage sources for hazard compare
//   valid_o .. opcode_o registered stage contents
//   hit_rs1_o/hit_rs2_o stage will write the given source (from held state)
//   stall_cnt_o, bubble_cnt_o  (macro only) performance counters
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned RD_W      = RD_W_DEF,
   parameter int unsigned OPC_W     = OPC_W_DEF,
   parameter int unsigned IMM_SEL_W = IMM_SEL_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   input  logic [RD_W-1:0]      rd_i,
   input  logic                 rd_wren_i,
   input  logic [DATA_W-1:0]    data_i,
   input  logic [IMM_SEL_W-1:0] imm_select_i,
   input  logic [OPC_W-1:0]     opcode_i,
   input  logic [RD_W-1:0]      rs1_i,
   input  logic [RD_W-1:0]      rs2_i,
   output logic                 valid_o,
   output logic [RD_W-1:0]      rd_o,
   output logic                 rd_wren_o,
   output logic [DATA_W-1:0]    data_o,
   output logic [IMM_SEL_W-1:0] imm_select_o,
   output logic [OPC_W-1:0]     opcode_o,
   output logic                 hit_rs1_o,
   output logic                 hit_rs2_o
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt_o,
   output logic [31:0]          bubble_cnt_o
`endif
);

   // Stage registers: reset and flush both produce a pure bubble.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         valid_o      <= 1'b0;
         rd_o         <= '0;
         rd_wren_o    <= 1'b0;
         data_o       <= '0;
         imm_select_o <= '0;
         opcode_o     <= OPC_W'(NOP_OPC);
      end else if (!stall_i) begin
         valid_o      <= valid_i;
         rd_o         <= rd_i;
         // Writes to x0 and writes from invalid slots never reach the file.
         rd_wren_o    <= rd_wren_i & valid_i & (rd_i != RD_W'(0));
         data_o       <= data_i;
         imm_select_o <= imm_select_i;
         opcode_o     <= opcode_i;
      end
   end

   // Hazard match from held state; x0 is never a hazard.
   assign hit_rs1_o = valid_o & rd_wren_o & (rs1_i != RD_W'(0)) & (rd_o == rs1_i);
   assign hit_rs2_o = valid_o & rd_wren_o & (rs2_i != RD_W'(0)) & (rd_o == rs2_i);

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic stall_inc;
   logic bubble_inc;

   // Bubble events: a flush, or a load of an invalid slot.
   assign stall_inc  = stall_i & ~flush_i;
   assign bubble_inc = flush_i | (~stall_i & ~valid_i);

   pipe_sat_cnt u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt_o)
   );

   pipe_sat_cnt u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (bubble_inc),
      .cnt_o (bubble_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: the driver computes the expected stage
// contents from a behavioural model and queues them; the monitor compares
// the DUT outputs one cycle later.
module tb_pipe_stage;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid, wren;
   logic [4:0]  rd, rs1, rs2, opc;
   logic [31:0] data;
   imm_sel_t    imm;

   logic        valid_q, wren_q, hit1, hit2;
   logic [4:0]  rd_q, opc_q;
   logic [31:0] data_q;
   logic [2:0]  imm_q;
`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt, bubble_cnt;
`endif

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        wren;
      logic [31:0] data;
      logic [2:0]  imm;
      logic [4:0]  opc;
      logic        hit1;
      logic        hit2;
`ifdef PIPE_STAGE_PERF_CNT_EN
      logic [31:0] scnt;
      logic [31:0] bcnt;
`endif
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic        m_valid = 1'b0, m_wren = 1'b0;
   logic [4:0]  m_rd = '0, m_opc = '0;
   logic [31:0] m_data = '0;
   logic [2:0]  m_imm = '0;
   logic [31:0] m_scnt = '0, m_bcnt = '0;

   pipe_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall),
      .flush_i      (flush),
      .valid_i      (valid),
      .rd_i         (rd),
      .rd_wren_i    (wren),
      .data_i       (data),
      .imm_select_i (imm),
      .opcode_i     (opc),
      .rs1_i        (rs1),
      .rs2_i        (rs2),
      .valid_o      (valid_q),
      .rd_o         (rd_q),
      .rd_wren_o    (wren_q),
      .data_o       (data_q),
      .imm_select_o (imm_q),
      .opcode_o     (opc_q),
      .hit_rs1_o    (hit1),
      .hit_rs2_o    (hit2)
`ifdef PIPE_STAGE_PERF_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt),
      .bubble_cnt_o (bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs (caller is at a negedge) and queue the outcome.
   task automatic drive_push(input logic r, s, f, v, input logic [4:0] rd_v,
                             input logic w, input logic [31:0] d, input logic [2:0] im,
                             input logic [4:0] op, input logic [4:0] a, b);
      obs_t e;
      rst = r; stall = s; flush = f; valid = v; rd = rd_v; wren = w;
      data = d; imm = im; opc = op; rs1 = a; rs2 = b;
      if (r) begin
         m_scnt = '0; m_bcnt = '0;
      end else begin
         if (s && !f && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
         if ((f || (!s && !v)) && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
      end
      if (r || f) begin
         m_valid = 0; m_rd = 0; m_wren = 0; m_data = 0; m_imm = 0; m_opc = 0;
      end else if (!s) begin
         m_valid = v; m_rd = rd_v; m_data = d; m_imm = im; m_opc = op;
         m_wren = w && v && (rd_v != 0);
      end
      e = '0;
      e.valid = m_valid; e.rd = m_rd; e.wren = m_wren; e.data = m_data;
      e.imm = m_imm; e.opc = m_opc;
      e.hit1 = m_valid && m_wren && a != 0 && m_rd == a;
      e.hit2 = m_valid && m_wren && b != 0 && m_rd == b;
`ifdef PIPE_STAGE_PERF_CNT_EN
      e.scnt = m_scnt; e.bcnt = m_bcnt;
`endif
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, s, f, v, input logic [4:0] rd_v,
                       input logic w, input logic [31:0] d, input logic [2:0] im,
                       input logic [4:0] op, input logic [4:0] a, b);
      @(negedge clk);
      drive_push(r, s, f, v, rd_v, w, d, im, op, a, b);
   endtask

   // Monitor: one queued expectation per clock once stimulus has started.
   initial begin
      obs_t e, act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act = '0;
            act.valid = valid_q; act.rd = rd_q; act.wren = wren_q; act.data = data_q;
            act.imm = imm_q; act.opc = opc_q; act.hit1 = hit1; act.hit2 = hit2;
`ifdef PIPE_STAGE_PERF_CNT_EN
            act.scnt = stall_cnt; act.bcnt = bubble_cnt;
`endif
            total++;
            if (act !== e) begin
               bad++;
               $display("FAIL stage_out t=%0t act=%h exp=%h", $time, act, e);
            end
         end
      end
   end

   initial begin
      rst = 1; stall = 0; flush = 0; valid = 0; wren = 0;
      rd = 0; rs1 = 0; rs2 = 0; opc = 0; data = 0; imm = 0;

      // Reset with every input nonzero
      repeat (2) step(1, 1, 1, 1, 5'd9, 1, 32'hFFFF_FFFF, 3'd7, 5'd31, 5'd9, 5'd9);

      // Load and x0 suppression
      step(0, 0, 0, 1, 5'd5, 1, 32'hDEAD_BEEF, 3'd2, 5'd12, 5'd5, 5'd0);
      step(0, 0, 0, 1, 5'd0, 1, 32'hCAFE_F00D, 3'd1, 5'd4, 5'd0, 5'd0);

      // Stall hold with hazard on rs1
      step(0, 0, 0, 1, 5'd7, 1, 32'h1234_5678, 3'd3, 5'd8, 5'd7, 5'd1);
      repeat (3) step(0, 1, 0, 1, 5'd2, 1, $urandom, 3'd5, 5'd17, 5'd7, 5'd2);

      // Flush wins over stall
      step(0, 0, 0, 1, 5'd9, 1, 32'h0000_0099, 3'd4, 5'd19, 5'd9, 5'd9);
      step(0, 1, 1, 1, 5'd9, 1, 32'h0000_0011, 3'd4, 5'd19, 5'd9, 5'd9);

      // Hazard compare
      step(0, 0, 0, 1, 5'd3, 1, 32'h3333_3333, 3'd0, 5'd6, 5'd3, 5'd4);
      step(0, 1, 0, 0, 5'd8, 0, 32'h0, 3'd0, 5'd0, 5'd0, 5'd3);

      // Counter directed sequence: 4 stalls then 2 flushes after reset
      step(1, 0, 0, 1, 5'd1, 1, 32'h1, 3'd1, 5'd1, 5'd0, 5'd0);
      repeat (4) step(0, 1, 0, 1, 5'd1, 1, 32'h1, 3'd1, 5'd1, 5'd0, 5'd0);
      repeat (2) step(0, 0, 1, 1, 5'd1, 1, 32'h1, 3'd1, 5'd1, 5'd0, 5'd0);

`ifdef PIPE_STAGE_PERF_CNT_EN
      // Saturation: preset the stall counter near the ceiling
      @(negedge clk);
      force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
      #1;
      release dut.u_stall_cnt.cnt;
      m_scnt = 32'hFFFF_FFFE;
      drive_push(0, 1, 0, 1, 5'd1, 1, 32'h1, 3'd1, 5'd1, 5'd0, 5'd0);
      repeat (2) step(0, 1, 0, 1, 5'd1, 1, 32'h1, 3'd1, 5'd1, 5'd0, 5'd0);
`endif

      // Randomized traffic; small register range to exercise hazards and x0
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 32) == 0, ($urandom % 4) == 0, ($urandom % 10) == 0,
              ($urandom % 4) != 0, 5'($urandom % 8), 1'($urandom), $urandom,
              3'($urandom), 5'($urandom), 5'($urandom % 8), 5'($urandom % 8));
      end

      // Let the monitor drain, bounded
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
